// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: W-bit adder that processes operands one nibble per cycle
// through an external 4-bit ripple-carry adder, with valid/ready handshakes.
`default_nettype none

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a_in,
  input  logic [4*NIBBLES-1:0]   b_in,
  input  logic                   cin_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   zero,
  output logic                   ovf,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    result_q, result_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = 4'h0;
    add_b     = 4'h0;
    add_cin   = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin_in;
          idx_d   = '0;
          state_d = S_ADD;
        end
      end

      S_ADD: begin
        // Result nibbles are overwritten in place, so the previous sum stays
        // visible in the upper nibbles until this pass reaches them.
        add_a   = a_q[{idx_q, 2'b00} +: 4];
        add_b   = b_q[{idx_q, 2'b00} +: 4];
        add_cin = carry_q;
        result_d[{idx_q, 2'b00} +: 4] = add_sum;
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = (result_q == '0);
  assign ovf    = (a_q[W-1] == b_q[W-1]) && (result_q[W-1] != a_q[W-1]);

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed self-checking bench for nibble_serial_adder
// (default 4-nibble instance plus a 1-nibble instance).
`default_nettype none

module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;
  int          n_checks;
  int          n_fail;

  // 4-nibble instance
  logic        in_valid, in_ready, cin_in, out_valid, out_ready;
  logic [15:0] a_in, b_in, result;
  logic        cout, zero, ovf;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic [4:0]  ext_sum;

  // 1-nibble instance
  logic        in_valid1, in_ready1, cin_in1, out_valid1, out_ready1;
  logic [3:0]  a_in1, b_in1, result1;
  logic        cout1, zero1, ovf1;
  logic [3:0]  add_a1, add_b1, add_sum1;
  logic        add_cin1, add_cout1;
  logic [4:0]  ext_sum1;

  // External 4-bit ripple-carry adders
  assign ext_sum  = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
  assign add_sum  = ext_sum[3:0];
  assign add_cout = ext_sum[4];
  assign ext_sum1  = {1'b0, add_a1} + {1'b0, add_b1} + {4'b0, add_cin1};
  assign add_sum1  = ext_sum1[3:0];
  assign add_cout1 = ext_sum1[4];

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .zero(zero), .ovf(ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a_in(a_in1), .b_in(b_in1), .cin_in(cin_in1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .result(result1), .cout(cout1), .zero(zero1), .ovf(ovf1),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
    .add_sum(add_sum1), .add_cout(add_cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request on the 4-nibble instance; returns cycles from the accept
  // edge to out_valid and the add_cin seen in each ADD cycle (bit i = cycle i).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        output int lat, output logic [3:0] cin_trace);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    a_in = a; b_in = b; cin_in = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    cin_trace = 4'h0;
    while (!out_valid && lat < 20) begin
      if (lat < 4) cin_trace[lat] = add_cin;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || result !== 16'h0000 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b result=%h cout=%b expected 0/0000/0", out_valid, result, cout);
    end
    n_checks++;
    if (add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_adder_port: got a=%h b=%h cin=%b expected 0/0/0", add_a, add_b, add_cin);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || in_ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b/%b expected 1/1", in_ready, in_ready1);
    end
  endtask

  task automatic test_basic();
    int lat;
    logic [3:0] tr;
    run_op(16'h1234, 16'h4321, 1'b1, lat, tr);
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d expected 4", lat);
    end
    n_checks++;
    if (result !== 16'h5556 || cout !== 1'b0 || zero !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_sum: got %h c=%b z=%b o=%b expected 5556 c=0 z=0 o=0", result, cout, zero, ovf);
    end
    release_result();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_return_idle: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_carry_chain();
    int lat;
    logic [3:0] tr;
    run_op(16'hFFFF, 16'h0001, 1'b0, lat, tr);
    n_checks++;
    if (result !== 16'h0000 || cout !== 1'b1 || zero !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL carry_sum: got %h c=%b z=%b o=%b expected 0000 c=1 z=1 o=0", result, cout, zero, ovf);
    end
    n_checks++;
    if (tr !== 4'b1110) begin
      n_fail++;
      $display("FAIL carry_trace: got %b expected 1110 (cycle0 in bit0)", tr);
    end
    release_result();
  endtask

  task automatic test_overflow();
    int lat;
    logic [3:0] tr;
    run_op(16'h7FFF, 16'h0001, 1'b0, lat, tr);
    n_checks++;
    if (result !== 16'h8000 || cout !== 1'b0 || zero !== 1'b0 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_pos: got %h c=%b z=%b o=%b expected 8000 c=0 z=0 o=1", result, cout, zero, ovf);
    end
    release_result();
    run_op(16'h8000, 16'h8000, 1'b0, lat, tr);
    n_checks++;
    if (result !== 16'h0000 || cout !== 1'b1 || zero !== 1'b1 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_neg: got %h c=%b z=%b o=%b expected 0000 c=1 z=1 o=1", result, cout, zero, ovf);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [3:0] tr;
    run_op(16'h0F0F, 16'h0101, 1'b0, lat, tr);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a_in = 16'hAAAA; b_in = 16'h5555;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'h1010 || cout !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got valid=%b ready=%b %h c=%b expected 1/0/1010/0", i, out_valid, in_ready, result, cout);
      end
    end
    in_valid = 1'b0;
    release_result();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 16'h1010) begin
      n_fail++;
      $display("FAIL hold_release: got valid=%b ready=%b %h expected 0/1/1010", out_valid, in_ready, result);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    logic [3:0] tr;
    logic seen;
    a_in = 16'hFFFF; b_in = 16'hFFFF; cin_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (result !== 16'h0000 || cout !== 1'b0 || out_valid !== 1'b0 || add_a !== 4'h0 || add_cin !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_clear: got %h c=%b valid=%b add_a=%h add_cin=%b expected all 0", result, cout, out_valid, add_a, add_cin);
    end
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_valid: got out_valid pulse=%b expected 0", seen);
    end
    run_op(16'h0002, 16'h0003, 1'b0, lat, tr);
    n_checks++;
    if (result !== 16'h0005 || cout !== 1'b0 || lat !== 4) begin
      n_fail++;
      $display("FAIL abort_next: got %h c=%b lat=%0d expected 0005 c=0 lat=4", result, cout, lat);
    end
    release_result();
  endtask

  task automatic test_nibbles1();
    int lat;
    a_in1 = 4'hF; b_in1 = 4'h1; cin_in1 = 1'b0; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL n1_latency: got %0d expected 1", lat);
    end
    n_checks++;
    if (result1 !== 4'h0 || cout1 !== 1'b1 || zero1 !== 1'b1 || ovf1 !== 1'b0) begin
      n_fail++;
      $display("FAIL n1_sum: got %h c=%b z=%b o=%b expected 0 c=1 z=1 o=0", result1, cout1, zero1, ovf1);
    end
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    n_checks++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL n1_idle: got valid=%b ready=%b expected 0/1", out_valid1, in_ready1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    in_valid = 1'b0; out_ready = 1'b0; cin_in = 1'b0; a_in = '0; b_in = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; cin_in1 = 1'b0; a_in1 = '0; b_in1 = '0;
    test_reset();
    test_basic();
    test_carry_chain();
    test_overflow();
    test_backpressure();
    test_reset_abort();
    test_nibbles1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
